// File: rtl/serial_adder_unit.sv
// Bit-serial LSB-first adder with a registered carry and a start/busy/done handshake.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' port for two's-complement subtraction.
module serial_adder_unit #(
    parameter int W  = 8,
    parameter int CW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   sha_q, sha_d, shb_q, shb_d, sum_q, sum_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           carry_q, carry_d, cout_q, cout_d;
    logic           accept, last, s_bit, c_bit;
    logic [W-1:0]   ld_b;
    logic           ld_c;

`ifdef SERIAL_ADDER_SUB_EN
    // a - b == a + ~b + 1; cout then reads as "no borrow"
    assign ld_b = sub ? ~op_b : op_b;
    assign ld_c = sub ? 1'b1  : cin;
`else
    assign ld_b = op_b;
    assign ld_c = cin;
`endif

    assign accept = ((state_q == IDLE) || (state_q == DONE)) && start;
    assign last   = (state_q == RUN) && (cnt_q == CW'(W-1));
    assign s_bit  = sha_q[0] ^ shb_q[0] ^ carry_q;
    assign c_bit  = (sha_q[0] & shb_q[0]) | (sha_q[0] & carry_q) | (shb_q[0] & carry_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    if (start) state_d = RUN;
                     else       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_comb begin
        sha_d   = sha_q;
        shb_d   = shb_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        if (accept) begin
            sha_d   = op_a;
            shb_d   = ld_b;
            carry_d = ld_c;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            sha_d   = sha_q >> 1;
            shb_d   = shb_q >> 1;
            sum_d   = {s_bit, sum_q[W-1:1]};
            carry_d = c_bit;
            cnt_d   = cnt_q + CW'(1);
            if (last) cout_d = c_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sha_q   <= '0;
            shb_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_unit.sv
// Directed bench for serial_adder_unit: expected results queued at launch, checked at done.
module tb_serial_adder_unit;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int vectors = 0;
    int miscompares = 0;
    logic [W:0] sb[$];

    always #5 clk = ~clk;

    serial_adder_unit #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a new op at a negedge; the following posedge accepts it.
    task automatic launch(input logic [W-1:0] a, b, input logic c, s);
        logic [W:0] full;
        @(negedge clk);
        op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
        if (s) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else   full = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        sb.push_back(full);
    endtask

    // Called at the negedge just after the accepting edge.
    task automatic wait_check(input string tag, input bit scramble);
        int n;
        logic [W:0] e;
        n = 0;
        while (done !== 1'b1 && n < 3*W) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            if (scramble) begin
                op_a  = W'($urandom);
                op_b  = W'($urandom);
                cin   = 1'($urandom);
                start = (n < W-2) ? 1'($urandom) : 1'b0;
            end
            @(negedge clk);
            n++;
        end
        if (scramble) start = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'(W));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_sum"},  32'(sum),  32'(e[W-1:0]));
            check({tag, "_cout"}, 32'(cout), 32'(e[W]));
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, b, input logic c, s,
                          input bit scramble);
        logic [W-1:0] held;
        launch(a, b, c, s);
        @(negedge clk);
        start = 1'b0;
        wait_check(tag, scramble);
        held = sum;
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_held"}, 32'(sum), 32'(held));
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_3a_45", 8'h3A, 8'h45, 1'b0, 1'b0, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op("add_80_80", 8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
        run_op("scramble",  8'hA5, 8'h3C, 1'b1, 1'b0, 1'b1);

        // Back-to-back: start held high across DONE
        launch(8'h11, 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        wait_check("b2b_first", 1'b0);
        op_a = 8'h10; op_b = 8'h20; cin = 1'b0;
        sb.push_back({1'b0, 8'h30});
        @(negedge clk);
        start = 1'b0;
        check("b2b_rerun_busy", 32'(busy), 32'd1);
        check("b2b_rerun_done", 32'(done), 32'd0);
        wait_check("b2b_second", 1'b0);
        @(negedge clk);

        // X on start while idle must not corrupt state
        start = 1'bx;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        check("xstart_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("xstart_idle_done", 32'(done), 32'd0);
        check("xstart_idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset at cnt==4
        launch(8'h55, 8'h0F, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum",  32'(sum),  32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        void'(sb.pop_back());
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (W+2) begin
            @(negedge clk);
            check("abort_still_idle", 32'(done | busy), 32'd0);
        end
        run_op("post_rst", 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
        run_op("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1, 1'b0);
        run_op("sub0_add",  8'h3A, 8'h45, 1'b1, 1'b0, 1'b0);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
